// File: rtl/sram_1rw_param.sv
// sram_1rw_param: parametrised single-port (1RW) SRAM model with a per-byte
// write mask, a valid/ready request port, a registered read response and a
// zero-initialisation sequencer that runs after reset and whenever clear pulses.
// Optional build macro SRAM_1RW_PARITY_EN adds per-byte even parity storage,
// an inject_err input for corrupting stored parity and an rsp_err output.
module sram_1rw_param #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 256,
    parameter int ABITS = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ABITS-1:0]     req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    input  logic [WIDTH/8-1:0]   req_wmask,
    output logic                 rsp_valid,
    output logic [WIDTH-1:0]     rsp_rdata,
    input  logic                 clear,
`ifdef SRAM_1RW_PARITY_EN
    input  logic                 inject_err,
    output logic                 rsp_err,
`endif
    output logic                 init_done
);

    localparam int NB = WIDTH / 8;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ABITS-1:0] cnt;
    logic [ABITS-1:0] cnt_next;
    logic             accept;
    logic             in_range;
    logic             do_write;
    logic             do_read;

    logic [WIDTH-1:0] mem [DEPTH];
`ifdef SRAM_1RW_PARITY_EN
    logic [NB-1:0]    par [DEPTH];

    // Even parity of each byte of a word, one bit per byte.
    function automatic logic [NB-1:0] byte_parity(input logic [WIDTH-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
`endif

    // Addresses beyond DEPTH exist only when DEPTH is not a power of two.
    assign in_range  = ({1'b0, req_addr} < (ABITS+1)'(DEPTH));
    // clear wins over a same-cycle request, so ready drops combinationally.
    assign req_ready = (state == READY) & ~clear;
    assign init_done = (state == READY);
    assign accept    = req_valid & req_ready;
    assign do_write  = accept & req_write & in_range;
    assign do_read   = accept & ~req_write;

    // State and init-counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state: INIT sweeps every word once, clear restarts the sweep.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            INIT: begin
                if (clear) begin
                    cnt_next = '0;
                end else if (cnt == ABITS'(DEPTH - 1)) begin
                    state_next = READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            READY: begin
                if (clear) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Array write port: zero fill during INIT, byte-masked writes in READY.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
`ifdef SRAM_1RW_PARITY_EN
            par[cnt] <= '0;
`endif
        end else if (do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (req_wmask[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef SRAM_1RW_PARITY_EN
                    par[req_addr][i] <= (^req_wdata[8*i +: 8]) ^ inject_err;
`endif
                end
            end
        end
    end

    // Read response register: pulses valid, holds data until the next read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef SRAM_1RW_PARITY_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= do_read;
            if (do_read) begin
                rsp_rdata <= in_range ? mem[req_addr] : '0;
`ifdef SRAM_1RW_PARITY_EN
                rsp_err   <= in_range ? |(byte_parity(mem[req_addr]) ^ par[req_addr]) : 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw_param.sv
// tb_sram_1rw_param: randomized and directed bench for sram_1rw_param
// (WIDTH=32, DEPTH=16) against a word-array reference model.
module tb_sram_1rw_param;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int NB = W / 8;
    localparam int AB = $clog2(D);

    logic          clock = 1'b0;
    logic          resetn;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AB-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic [NB-1:0] req_wmask;
    logic          rsp_valid;
    logic [W-1:0]  rsp_rdata;
    logic          clear;
    logic          init_done;
`ifdef SRAM_1RW_PARITY_EN
    logic          inject_err;
    logic          rsp_err;
    logic [NB-1:0] m_bad [D];
    logic          e_err;
`endif

    // reference model
    logic [W-1:0]  m_mem [D];
    int            init_left;
    logic          e_vld;
    logic [W-1:0]  e_data;

    int total = 0;
    int bad   = 0;

    sram_1rw_param #(.WIDTH(W), .DEPTH(D)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .clear     (clear),
`ifdef SRAM_1RW_PARITY_EN
        .inject_err(inject_err),
        .rsp_err   (rsp_err),
`endif
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        init_left = D;
        e_vld     = 1'b0;
        e_data    = '0;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
`ifdef SRAM_1RW_PARITY_EN
        e_err = 1'b0;
        for (int i = 0; i < D; i++) m_bad[i] = '0;
`endif
    endtask

    // Compare all outputs with the model, then advance one clock and update the model.
    task automatic tick();
        logic rdy;
        logic acc;
        #3;
        chk("req_ready", req_ready, (init_left == 0) && !clear);
        chk("init_done", init_done, init_left == 0);
        chk("rsp_valid", rsp_valid, e_vld);
        chk("rsp_rdata", rsp_rdata, e_data);
`ifdef SRAM_1RW_PARITY_EN
        chk("rsp_err", rsp_err, e_err);
`endif
        @(posedge clock);
        rdy   = (init_left == 0) && !clear;
        acc   = req_valid && rdy;
        e_vld = acc && !req_write;
        if (acc && !req_write) begin
            e_data = m_mem[req_addr];
`ifdef SRAM_1RW_PARITY_EN
            e_err = |m_bad[req_addr];
`endif
        end
        if (acc && req_write) begin
            for (int i = 0; i < NB; i++) begin
                if (req_wmask[i]) begin
                    m_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
`ifdef SRAM_1RW_PARITY_EN
                    m_bad[req_addr][i] = inject_err;
`endif
                end
            end
        end
        if (init_left == 0) begin
            if (clear) begin
                init_left = D;
                for (int i = 0; i < D; i++) m_mem[i] = '0;
`ifdef SRAM_1RW_PARITY_EN
                for (int i = 0; i < D; i++) m_bad[i] = '0;
`endif
            end
        end else begin
            init_left = clear ? D : init_left - 1;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [AB-1:0] a,
                         input logic [W-1:0] d, input logic [NB-1:0] m,
                         input logic c, input logic inj);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        clear     = c;
`ifdef SRAM_1RW_PARITY_EN
        inject_err = inj;
`else
        if (inj) $display("note: inject ignored without parity build");
`endif
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] m);
        drive(1'b1, 1'b1, a, d, m, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [AB-1:0] a);
        drive(1'b1, 1'b0, a, '0, '0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop at once.
    task automatic do_reset();
        req_valid = 1'b0;
        req_write = 1'b0;
        clear     = 1'b0;
        resetn    = 1'b0;
        #1;
        m_reset();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
`ifdef SRAM_1RW_PARITY_EN
        chk("rst_rsp_err", rsp_err, 1'b0);
`endif
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        clear     = 1'b0;
`ifdef SRAM_1RW_PARITY_EN
        inject_err = 1'b0;
`endif
        @(posedge clock);
        #1;
        do_reset();

        // INIT sweep: ready stays low for exactly D cycles
        idle(D + 1);
        for (int a = 0; a < D; a++) rd(AB'(a));
        idle(1);

        // full write then read back
        wr(4'd3, 32'hA5A5_A5A5, 4'hF);
        rd(4'd3);
        idle(1);

        // byte-masked write
        wr(4'd3, 32'hFFFF_FFFF, 4'h1);
        rd(4'd3);
        idle(1);

        // response holds across a write to the same address
        rd(4'd3);
        wr(4'd3, 32'h0, 4'hF);
        idle(2);
        rd(4'd3);
        idle(1);

        // wmask=0 write has no effect
        wr(4'd9, 32'h1234_5678, 4'hF);
        wr(4'd9, 32'hFFFF_FFFF, 4'h0);
        rd(4'd9);
        idle(1);

        // clear with a pending read response and a same-cycle blocked write
        wr(4'd7, 32'hDEAD_BEEF, 4'hF);
        rd(4'd7);
        drive(1'b1, 1'b1, 4'd8, 32'h5555_5555, 4'hF, 1'b1, 1'b0);
        idle(D + 1);
        rd(4'd7);
        rd(4'd8);
        rd(4'd9);
        idle(1);

        // clear during INIT restarts the sweep
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle(5);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle(D + 1);

        // reset in the middle of INIT
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle(6);
        do_reset();
        idle(D + 1);

        // reset while a read response is in flight
        wr(4'd2, 32'hCAFE_F00D, 4'hF);
        rd(4'd2);
        do_reset();
        idle(D + 1);

`ifdef SRAM_1RW_PARITY_EN
        // parity error injection and recovery
        drive(1'b1, 1'b1, 4'd5, 32'h0123_4567, 4'hF, 1'b0, 1'b1);
        rd(4'd5);
        idle(1);
        chk("parity_inject", rsp_err, 1'b1);
        wr(4'd5, 32'h0123_4567, 4'hF);
        rd(4'd5);
        idle(1);
        chk("parity_clean", rsp_err, 1'b0);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  AB'($urandom_range(0, D - 1)),
                  W'($urandom),
                  NB'($urandom),
                  1'($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 7) == 0));
        end
        idle(D + 2);
        for (int a = 0; a < D; a++) rd(AB'(a));
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
